// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared single-port RAM.
// One transaction is outstanding at a time; a bounded data streak keeps fetches from starving.
module mem_port_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_inst,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] d_wmask,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] ram_wmask,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     dstreak_q, dstreak_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] wmask_q, wmask_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_gnt_s, d_gnt_s;

  // Arbitration, request latching and completion capture.
  always_comb begin
    state_d     = state_q;
    dstreak_d   = dstreak_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_inst_d   = if_inst_q;
    d_rdata_d   = d_rdata_q;
    if_gnt_s    = 1'b0;
    d_gnt_s     = 1'b0;
    case (state_q)
      IDLE: begin
        // Data normally wins; a fetch waiting through a full streak takes the next slot.
        if (d_req && !(if_req && (dstreak_q == STREAK_MAX))) begin
          d_gnt_s = 1'b1;
          state_d = BUSY_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          wmask_d = d_wmask;
          if (if_req) begin
            if (dstreak_q != STREAK_MAX) begin
              dstreak_d = dstreak_q + SW'(1);
            end else begin
              dstreak_d = dstreak_q;
            end
          end else begin
            dstreak_d = '0;
          end
        end else if (if_req) begin
          if_gnt_s  = 1'b1;
          state_d   = BUSY_I;
          addr_d    = if_addr;
          we_d      = 1'b0;
          wdata_d   = '0;
          wmask_d   = '0;
          dstreak_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I: begin
        if (ram_ack) begin
          state_d     = IDLE;
          if_rvalid_d = 1'b1;
          if_inst_d   = addr_q[2] ? ram_rdata[63:32] : ram_rdata[31:0];
        end else begin
          state_d = BUSY_I;
        end
      end
      BUSY_D: begin
        if (ram_ack) begin
          state_d    = IDLE;
          d_rvalid_d = 1'b1;
          if (!we_q) begin
            d_rdata_d = ram_rdata;
          end else begin
            d_rdata_d = d_rdata_q;
          end
        end else begin
          state_d = BUSY_D;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dstreak_q   <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_inst_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      dstreak_q   <= dstreak_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_inst_q   <= if_inst_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Grants are combinational but must stay quiet while reset is held.
  assign if_gnt    = if_gnt_s & ~rst;
  assign d_gnt     = d_gnt_s & ~rst;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_inst   = if_inst_q;
  assign d_rdata   = d_rdata_q;
  assign ram_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign ram_we    = (state_q == BUSY_D) && we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_wmask = wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model of arbitration, latency and RAM contents.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst;
  logic if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [31:0] if_inst;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_wmask, d_rdata;
  logic ram_req, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_wmask, ram_rdata;
  logic ram_ack;
  logic ack_auto, ack_manual;
  assign ram_ack = ack_auto | ack_manual;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_inst(if_inst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask), .ram_ack(ram_ack), .ram_rdata(ram_rdata)
  );

  function automatic logic [63:0] init_word(input int i);
    if (i == 0) return 64'h1111_2222_3333_4444;
    return {32'h9E37_79B9 * 32'(i), 32'h7F4A_7C15 ^ 32'(i)};
  endfunction

  // RAM responder: 16-doubleword memory, ack after a chosen latency.
  logic [63:0] ram_mem [16];
  int fixed_lat = 0;
  int age_q, lat_q, eff_lat;
  assign eff_lat = (fixed_lat != 0) ? fixed_lat : lat_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_auto <= 1'b0;
      age_q <= 0;
      lat_q <= 1;
      ram_rdata <= '0;
      for (int i = 0; i < 16; i++) ram_mem[i] <= init_word(i);
    end else if (ack_auto) begin
      ack_auto <= 1'b0;
      age_q <= 0;
      lat_q <= int'($urandom_range(1, 3));
    end else if (ram_req) begin
      age_q <= age_q + 1;
      if (age_q + 1 == eff_lat) begin
        ack_auto <= 1'b1;
        ram_rdata <= ram_mem[ram_addr[6:3]];
        if (ram_we)
          ram_mem[ram_addr[6:3]] <= (ram_mem[ram_addr[6:3]] & ~ram_wmask) | (ram_wdata & ram_wmask);
      end
    end
  end

  // Reference model state
  logic [63:0] ref_mem [16];
  bit m_busy, m_owner_d, m_pend_i, m_pend_d, p_we;
  int m_streak;
  logic [AW-1:0] t_addr;
  logic t_we;
  logic [DW-1:0] t_wdata, t_wmask, t_exp, p_rdata;
  logic [31:0] p_inst;
  int cyc_no = 0;
  int last_ig = -1, last_dg = -1, last_irv = -1, last_drv = -1;
  int n_ig = 0, n_dg = 0;
  bit g_i, g_d, if_hold = 0, d_hold = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_pend_i = 0; m_pend_d = 0; m_streak = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic check_cycle();
    bit exp_ig, exp_dg;
    chk("if_rvalid", 64'(if_rvalid), 64'(m_pend_i));
    chk("d_rvalid", 64'(d_rvalid), 64'(m_pend_d));
    if (m_pend_i) chk("if_inst", 64'(if_inst), 64'(p_inst));
    if (m_pend_d && !p_we) chk("d_rdata", d_rdata, p_rdata);
    if (if_rvalid) last_irv = cyc_no;
    if (d_rvalid) last_drv = cyc_no;
    m_pend_i = 0; m_pend_d = 0;
    exp_ig = 0; exp_dg = 0;
    if (!m_busy) begin
      if (d_req && !(if_req && m_streak == MAXS)) exp_dg = 1;
      else if (if_req) exp_ig = 1;
    end
    chk("if_gnt", 64'(if_gnt), 64'(exp_ig));
    chk("d_gnt", 64'(d_gnt), 64'(exp_dg));
    chk("ram_req", 64'(ram_req), 64'(m_busy));
    if (m_busy) begin
      chk("ram_addr", ram_addr, t_addr);
      chk("ram_we", 64'(ram_we), 64'(m_owner_d && t_we));
      if (m_owner_d && t_we) begin
        chk("ram_wdata", ram_wdata, t_wdata);
        chk("ram_wmask", ram_wmask, t_wmask);
      end
    end
    if (m_busy && ram_ack) begin
      if (m_owner_d) m_pend_d = 1; else m_pend_i = 1;
      p_inst = t_addr[2] ? t_exp[63:32] : t_exp[31:0];
      p_rdata = t_exp;
      p_we = t_we;
      m_busy = 0;
    end else if (exp_dg) begin
      m_busy = 1; m_owner_d = 1;
      t_addr = d_addr; t_we = d_we; t_wdata = d_wdata; t_wmask = d_wmask;
      t_exp = ref_mem[d_addr[6:3]];
      if (d_we) ref_mem[d_addr[6:3]] = (t_exp & ~d_wmask) | (d_wdata & d_wmask);
      m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : m_streak) : 0;
      n_dg++; last_dg = cyc_no; g_d = 1;
    end else if (exp_ig) begin
      m_busy = 1; m_owner_d = 0;
      t_addr = if_addr; t_we = 0; t_wdata = '0; t_wmask = '0;
      t_exp = ref_mem[if_addr[6:3]];
      m_streak = 0;
      n_ig++; last_ig = cyc_no; g_i = 1;
    end
  endtask

  task automatic cyc();
    g_i = 0; g_d = 0;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc_no++;
    if (g_i && !if_hold) if_req = 1'b0;
    if (g_d && !d_hold) d_req = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (m_busy || m_pend_i || m_pend_d); k++) cyc();
    chk("drain_done", 64'(m_busy || m_pend_i || m_pend_d), 64'd0);
  endtask

  initial begin
    int start, dg_first, ig0, dg0, drv_before;
    rst = 1'b1; ack_manual = 1'b0;
    if_req = 1'b1; if_addr = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state with both requests asserted
    chk("rst_if_gnt", 64'(if_gnt), 64'd0);
    chk("rst_d_gnt", 64'(d_gnt), 64'd0);
    chk("rst_ram_req", 64'(ram_req), 64'd0);
    chk("rst_rvalids", 64'({if_rvalid, d_rvalid, ram_we}), 64'd0);
    chk("rst_if_inst", 64'(if_inst), 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_ram_fields", ram_addr | ram_wdata | ram_wmask, 64'd0);
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Fetch only, ack two cycles after ram_req
    fixed_lat = 2;
    if_req = 1'b1; if_addr = 64'h8000_0004;
    start = cyc_no;
    for (int k = 0; k < 40 && last_irv < start; k++) cyc();
    chk("f_gnt_cycle", 64'(last_ig), 64'(start));
    chk("f_rvalid_cycle", 64'(last_irv), 64'(start + 4));
    chk("f_inst", 64'(if_inst), 64'h1111_2222);

    // Simultaneous requests: data first, fetch on the d_rvalid cycle
    fixed_lat = 1;
    if_req = 1'b1; if_addr = 64'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h28;
    start = cyc_no;
    for (int k = 0; k < 60 && last_irv < start; k++) cyc();
    chk("sim_d_first", 64'(last_dg), 64'(start));
    chk("sim_f_on_drv", 64'(last_ig), 64'(last_drv));

    // Streak limit with both requests held
    fixed_lat = 0;
    if_hold = 1; d_hold = 1;
    if_req = 1'b1; if_addr = 64'h34; d_req = 1'b1; d_addr = 64'h40;
    ig0 = n_ig; dg0 = n_dg; dg_first = -1;
    for (int k = 0; k < 300 && n_ig < ig0 + 2; k++) begin
      cyc();
      if (dg_first < 0 && n_ig == ig0 + 1) dg_first = n_dg - dg0;
    end
    chk("streak_first", 64'(dg_first), 64'(MAXS));
    chk("streak_second", 64'(n_dg - dg0 - dg_first), 64'(MAXS));
    if_hold = 0; d_hold = 0;
    if_req = 1'b0; d_req = 1'b0;
    drain();

    // Masked write, held stable until ack, then read back
    fixed_lat = 3;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h18;
    d_wdata = 64'h0000_0000_DEAD_BEEF; d_wmask = 64'h0000_0000_FFFF_FFFF;
    start = cyc_no;
    cyc();
    chk("w_ram_we", 64'(ram_we), 64'd1);
    chk("w_ram_wmask", ram_wmask, 64'h0000_0000_FFFF_FFFF);
    chk("w_ram_wdata", ram_wdata, 64'h0000_0000_DEAD_BEEF);
    for (int k = 0; k < 30 && last_drv < start; k++) cyc();
    chk("w_drv_cycle", 64'(last_drv), 64'(start + 5));
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h18;
    cyc();
    drain();

    // Reset in the middle of a data read
    fixed_lat = 5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h50;
    cyc(); cyc();
    chk("pre_rst_ram_req", 64'(ram_req), 64'd1);
    drv_before = last_drv;
    rst = 1'b1;
    #1;
    chk("rst_async_ram_req", 64'(ram_req), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (8) cyc();
    chk("rst_no_drv", 64'(last_drv), 64'(drv_before));
    fixed_lat = 1;
    d_req = 1'b1; d_addr = 64'h58;
    start = cyc_no;
    cyc();
    chk("post_rst_gnt", 64'(last_dg), 64'(start));
    drain();

    // Stray ack while idle
    ack_manual = 1'b1;
    cyc();
    ack_manual = 1'b0;
    cyc();
    chk("stray_no_rv", 64'({if_rvalid, d_rvalid}), 64'd0);
    if_req = 1'b1; if_addr = 64'h8;
    start = cyc_no;
    cyc();
    chk("stray_idle_gnt", 64'(last_ig), 64'(start));
    drain();

    // Random traffic
    fixed_lat = 0;
    for (int c = 0; c < 500; c++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1;
        if_addr = {57'd0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2'b00};
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = {57'd0, 7'($urandom_range(0, 127))};
        d_wdata = {$urandom, $urandom};
        d_wmask = {$urandom, $urandom};
      end
      cyc();
    end
    if_req = 1'b0; d_req = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, meaning address width of all ports.
REQ-002 The block SHALL have parameter DATA_W, default 64, meaning RAM data and write-mask width.
REQ-003 The block SHALL have parameter MAX_DSTREAK, default 4, meaning the maximum number of consecutive data grants while a fetch waits.
REQ-004 The block SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  in  1  meaning asynchronous, active-high reset.
REQ-006 The block SHALL have port if_req  in  1  meaning fetch request; held with if_addr until if_gnt.
REQ-007 The block SHALL have port if_addr  in  ADDR_W  meaning fetch byte address.
REQ-008 The block SHALL have port if_gnt  out  1  meaning fetch request accepted this cycle.
REQ-009 The block SHALL have port if_rvalid  out  1  meaning one-cycle pulse, if_inst valid.
REQ-010 The block SHALL have port if_inst  out  32  meaning fetched instruction.
REQ-011 The block SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_W, d_wdata in DATA_W, d_wmask in DATA_W, meaning data request, write-enable, address, write data and per-bit write mask; held until d_gnt.
REQ-012 The block SHALL have ports d_gnt out 1, d_rvalid out 1, d_rdata out DATA_W, meaning data accepted, one-cycle completion pulse (read or write) and read data.
REQ-013 The block SHALL have ports ram_req out 1, ram_we out 1, ram_addr out ADDR_W, ram_wdata out DATA_W, ram_wmask out DATA_W, meaning the shared single-port RAM request.
REQ-014 The block SHALL have ports ram_ack in 1, ram_rdata in DATA_W, meaning RAM completion (any latency >= 1 cycle after ram_req rises) and RAM read data (64-bit doubleword).

Function
REQ-015 The FSM SHALL have states IDLE, BUSY_I, BUSY_D; at most one transaction is outstanding.
REQ-016 In IDLE, if_gnt/d_gnt SHALL be driven combinationally: d_req wins unless if_req=1 and dstreak==MAX_DSTREAK, in which case the fetch wins; only if_req -> fetch; neither -> stay IDLE.
REQ-017 On a grant, the block SHALL latch address (and for data: we, wdata, wmask) and move to BUSY_I or BUSY_D on the next edge.
REQ-018 In BUSY_x, ram_req SHALL be 1 with latched fields stable until the cycle ram_ack=1; ram_we SHALL be 0 for fetches.
REQ-019 On ram_ack in BUSY_x, the block SHALL register ram_rdata and return to IDLE; the owner's rvalid SHALL pulse for exactly the following cycle, in which a new grant may also be issued.
REQ-020 Latency: grant at cycle 0, ram_req from cycle 1, ram_ack at cycle k, rvalid and IDLE at cycle k+1.
REQ-021 if_inst SHALL equal captured rdata[63:32] when latched fetch address bit 2 is 1, else rdata[31:0].
REQ-022 d_rdata SHALL hold captured ram_rdata after read completion; after a write completion d_rdata is don't-care.
REQ-023 dstreak (width clog2(MAX_DSTREAK+1)) SHALL increment on a data grant made while if_req=1, saturating at MAX_DSTREAK; it SHALL clear on a fetch grant or on any data grant made with if_req=0.
REQ-024 ram_ack in IDLE SHALL be ignored; requests dropped before grant SHALL cause no action.
REQ-025 if_rvalid and d_rvalid SHALL never be 1 in the same cycle; at most one of if_gnt/d_gnt SHALL be 1 per cycle.

Reset
REQ-026 While rst=1, state SHALL be IDLE, dstreak 0, and all outputs 0 (ram_req, gnts, rvalids, if_inst, d_rdata, ram_* fields).
REQ-027 Reset mid-transaction SHALL drop ram_req immediately (asynchronously) and no rvalid SHALL follow for the aborted transaction.

Verification
REQ-028 Fetch only: if_addr=0x8000_0004, ram_ack 2 cycles after ram_req, ram_rdata=0x1111_2222_3333_4444 -> if_gnt cycle 0, if_rvalid cycle 4, if_inst=0x1111_2222.
REQ-029 Simultaneous if_req and d_req (dstreak 0) -> d_gnt first; fetch granted in the cycle d_rvalid pulses.
REQ-030 d_req held continuously with if_req held, MAX_DSTREAK=4 -> exactly 4 data grants, then 1 fetch grant, dstreak returns to 0.
REQ-031 Data write d_wmask=0x0000_0000_FFFF_FFFF, d_wdata=0xDEAD_BEEF -> ram_we=1, ram_wmask/ram_wdata match and stay stable until ram_ack; d_rvalid one cycle after ack.
REQ-032 rst asserted during BUSY_D with ram_req=1 -> ram_req 0 same cycle, no d_rvalid after release, next d_req granted from IDLE.
REQ-033 ram_ack pulsed while IDLE with no requests -> no rvalid, state remains IDLE.
